mux16_scan_ctrl: RTL and testbench

Sequential scan controller sitting directly upstream of the 16-to-1 two-level mux. It generates the mux's `sel1`/`sel2` select lines to walk all 16 mux inputs in order. It samples the mux output after one settle cycle and delivers each sampled bit downstream as a serial stream with valid/ready handshake. Typical use is reading a 16-bit parallel status word as a bit stream.

---
 rtl/mux16_scan_ctrl_pkg.sv | 7 +
 rtl/mux16_scan_ctrl_index_ctr.sv | 23 ++
 rtl/mux16_scan_ctrl.sv | 94 +++++++++
 tb/tb_mux16_scan_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mux16_scan_ctrl_pkg.sv
// mux16_scan_ctrl_pkg: shared FSM state encoding and scan index constants for the 16-input mux scanner
package mux16_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, DONE} state_t;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] IDX_FIRST_ASC = 4'd0;
  localparam logic [IDX_W-1:0] IDX_FIRST_DESC = 4'd15;
endpackage

// File: rtl/mux16_scan_ctrl_index_ctr.sv
// scan_index_ctr: 4-bit scan index counter with load, single-step enable and end-of-scan flag
// Ports: clk, reset_l (sync, active low), load/load_val (set index), step (advance one
// position in the scan direction), idx (current index), at_end (idx is the final index).
module scan_index_ctr
  import mux16_scan_ctrl_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic             at_end
);
  always_ff @(posedge clk) begin
    if (!reset_l) idx <= '0;
    else if (load) idx <= load_val;
    else if (step) idx <= DOWN ? idx - 1'b1 : idx + 1'b1;
  end
  assign at_end = idx == (DOWN ? IDX_FIRST_ASC : IDX_FIRST_DESC);
endmodule

// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: walks the selects of a 16:1 two-level mux and streams each sampled bit out with valid/ready
// Ports: clk, reset_l (sync, active low); start/abort control; sel1/sel2 mux selects
// (idx[1:0]/idx[3:2]); mux_y mux output; ser_bit/ser_valid/ser_ready/ser_last serial
// stream; busy (not IDLE), done (one-cycle end pulse), parity (XOR of transferred bits).
module mux16_scan_ctrl
  import mux16_scan_ctrl_pkg::*;
#(
  parameter bit DESCEND    = 1'b0,
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  input  logic       mux_y,
  output logic       ser_bit,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_last,
  output logic       busy,
  output logic       done,
  output logic       parity
);
  localparam logic [IDX_W-1:0] IDX_FIRST = DESCEND ? IDX_FIRST_DESC : IDX_FIRST_ASC;
  // The first bit waits SETTLE_CYC+1 cycles; later bits reload one lower so each costs
  // SETTLE_CYC+1 cycles including the PRESENT cycle, still giving mux_y SETTLE_CYC full cycles.
  localparam logic [1:0] CNT_INIT   = 2'(SETTLE_CYC);
  localparam logic [1:0] CNT_RELOAD = 2'(SETTLE_CYC - 1);
  state_t           state;
  logic [1:0]       cnt;
  logic [IDX_W-1:0] idx;
  logic             at_end;
  logic             load;
  logic             step;
  assign load = state == IDLE && start;
  assign step = state == PRESENT && ser_ready && !abort && !ser_last;
  scan_index_ctr #(.DOWN(DESCEND)) u_idx (
    .clk      (clk),
    .reset_l  (reset_l),
    .load     (load),
    .load_val (IDX_FIRST),
    .step     (step),
    .idx      (idx),
    .at_end   (at_end)
  );
  assign sel1 = idx[1:0];
  assign sel2 = idx[3:2];
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state     <= IDLE;
      cnt       <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      done      <= 1'b0;
      parity    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          parity <= 1'b0;
          cnt    <= CNT_INIT;
          state  <= SETTLE;
        end
        SETTLE: if (abort) begin
          state <= DONE;
          done  <= 1'b1;
        end else if (cnt == 2'd0) begin
          ser_bit   <= mux_y;
          ser_valid <= 1'b1;
          ser_last  <= at_end;
          state     <= PRESENT;
        end else cnt <= cnt - 2'd1;
        PRESENT: if (abort) begin
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          state     <= DONE;
          done      <= 1'b1;
        end else if (ser_ready) begin
          parity    <= parity ^ ser_bit;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          state     <= ser_last ? DONE : SETTLE;
          done      <= ser_last;
          cnt       <= CNT_RELOAD;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// tb_mux16_scan_ctrl: directed table-driven bench for three scanner configurations driving a behavioural 16:1 mux
module tb_mux16_scan_ctrl;
  typedef struct {
    int          d;
    logic [15:0] w;
    logic [15:0] exp_bits;
    logic        exp_par;
    int          exp_done;
    bit          stall;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ser_ready = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [1:0]  sel1_a [3];
  logic [1:0]  sel2_a [3];
  logic [2:0]  mux_y_a, ser_bit_a, ser_valid_a, ser_last_a, busy_a, done_a, parity_a;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [6];
  logic [15:0] got;
  int          n, cyc;
  logic        par;
  always #5 clk = ~clk;
  genvar g;
  for (g = 0; g < 3; g++) begin : g_mux
    assign mux_y_a[g] = data[{sel2_a[g], sel1_a[g]}];
  end
  mux16_scan_ctrl #(.DESCEND(1'b0), .SETTLE_CYC(1)) u0 (
    .clk(clk), .reset_l(reset_l), .start(start), .abort(abort), .sel1(sel1_a[0]), .sel2(sel2_a[0]),
    .mux_y(mux_y_a[0]), .ser_bit(ser_bit_a[0]), .ser_valid(ser_valid_a[0]), .ser_ready(ser_ready),
    .ser_last(ser_last_a[0]), .busy(busy_a[0]), .done(done_a[0]), .parity(parity_a[0]));
  mux16_scan_ctrl #(.DESCEND(1'b1), .SETTLE_CYC(1)) u1 (
    .clk(clk), .reset_l(reset_l), .start(start), .abort(abort), .sel1(sel1_a[1]), .sel2(sel2_a[1]),
    .mux_y(mux_y_a[1]), .ser_bit(ser_bit_a[1]), .ser_valid(ser_valid_a[1]), .ser_ready(ser_ready),
    .ser_last(ser_last_a[1]), .busy(busy_a[1]), .done(done_a[1]), .parity(parity_a[1]));
  mux16_scan_ctrl #(.DESCEND(1'b0), .SETTLE_CYC(3)) u2 (
    .clk(clk), .reset_l(reset_l), .start(start), .abort(abort), .sel1(sel1_a[2]), .sel2(sel2_a[2]),
    .mux_y(mux_y_a[2]), .ser_bit(ser_bit_a[2]), .ser_valid(ser_valid_a[2]), .ser_ready(ser_ready),
    .ser_last(ser_last_a[2]), .busy(busy_a[2]), .done(done_a[2]), .parity(parity_a[2]));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle;
    for (int i = 0; i < 300 && busy_a != 3'b000; i++) tick();
    check("idle_wait", 32'(busy_a), 0);
  endtask
  task automatic run(input vec_t v);
    logic [15:0] bits;
    int          k, c, done_cyc, first_v, prev_rise, spacing_err, unstable, lasts, last_n, s;
    logic        prev_valid, stalled, held_bit, held_last;
    bits = 0; k = 0; c = 0; done_cyc = -1; first_v = -1; prev_rise = -1; spacing_err = 0;
    unstable = 0; lasts = 0; last_n = -1; prev_valid = 0; stalled = 0; held_bit = 0; held_last = 0;
    s = (v.d == 2) ? 3 : 1;
    wait_idle();
    data = v.w;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy_a[v.d]), 1);
    if (v.d == 1) begin
      check("desc_first_sel2", 32'(sel2_a[1]), 3);
      check("desc_first_sel1", 32'(sel1_a[1]), 3);
    end
    for (int i = 0; i < 2000 && done_cyc < 0; i++) begin
      ser_ready = v.stall ? (c % 3 == 2) : 1'b1;
      if (ser_valid_a[v.d] && !prev_valid) begin
        if (first_v < 0) first_v = c;
        else if (c - prev_rise != s + 1) spacing_err++;
        prev_rise = c;
      end
      if (stalled && (ser_bit_a[v.d] !== held_bit || ser_last_a[v.d] !== held_last || ser_valid_a[v.d] !== 1'b1))
        unstable++;
      stalled = ser_valid_a[v.d] && !ser_ready;
      held_bit = ser_bit_a[v.d];
      held_last = ser_last_a[v.d];
      if (ser_valid_a[v.d] && ser_ready) begin
        if (k < 16) bits[k] = ser_bit_a[v.d];
        if (ser_last_a[v.d]) begin
          lasts++;
          last_n = k;
        end
        k++;
      end
      prev_valid = ser_valid_a[v.d];
      tick();
      c++;
      if (done_a[v.d]) done_cyc = c;
    end
    ser_ready = 1'b1;
    check("stream_bits", 32'(bits), 32'(v.exp_bits));
    check("transfer_count", k, 16);
    check("last_count", lasts, 1);
    check("last_position", last_n, 15);
    check("parity_at_done", 32'(parity_a[v.d]), 32'(v.exp_par));
    check("first_valid_cycle", first_v, s + 1);
    check("stall_stability", unstable, 0);
    if (v.exp_done > 0) begin
      check("done_cycle", done_cyc, v.exp_done);
      check("valid_spacing", spacing_err, 0);
    end else check("done_seen", 32'(done_cyc > 0), 1);
    tick();
    check("done_one_cycle", 32'(done_a[v.d]), 0);
    check("busy_after_done", 32'(busy_a[v.d]), 0);
    tick();
    tick();
    check("parity_hold", 32'(parity_a[v.d]), 32'(v.exp_par));
  endtask
  initial begin
    tbl[0] = '{0, 16'hA5C3, 16'hA5C3, 1'b0, 33, 1'b0};
    tbl[1] = '{1, 16'hA5C3, 16'hC3A5, 1'b0, 33, 1'b0};
    tbl[2] = '{0, 16'h0001, 16'h0001, 1'b1, -1, 1'b1};
    tbl[3] = '{2, 16'hFFFF, 16'hFFFF, 1'b0, 65, 1'b0};
    tbl[4] = '{0, 16'h1234, 16'h1234, 1'b1, 33, 1'b0};
    tbl[5] = '{1, 16'h0001, 16'h8000, 1'b1, 33, 1'b0};
    reset_l = 1'b0;
    tick();
    tick();
    check("rst_sel1", 32'(sel1_a[0]), 0);
    check("rst_sel2", 32'(sel2_a[0]), 0);
    check("rst_ser_bit", 32'(ser_bit_a), 0);
    check("rst_ser_valid", 32'(ser_valid_a), 0);
    check("rst_ser_last", 32'(ser_last_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_parity", 32'(parity_a), 0);
    reset_l = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy_a), 0);
    check("idle_abort_done", 32'(done_a), 0);
    for (int t = 0; t < 6; t++) run(tbl[t]);
    wait_idle();
    data = 16'h0011;
    ser_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    par = 1'b0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      if (ser_valid_a[0]) begin
        par ^= ser_bit_a[0];
        n++;
      end
      tick();
    end
    for (int i = 0; i < 20 && !ser_valid_a[0]; i++) tick();
    check("abort_5th_valid", 32'(ser_valid_a[0]), 1);
    check("abort_5th_bit", 32'(ser_bit_a[0]), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done", 32'(done_a[0]), 1);
    check("abort_valid_drop", 32'(ser_valid_a[0]), 0);
    check("abort_busy_still", 32'(busy_a[0]), 1);
    tick();
    check("abort_busy_low", 32'(busy_a[0]), 0);
    check("abort_parity", 32'(parity_a[0]), 32'(par));
    check("abort_parity_value", 32'(parity_a[0]), 1);
    wait_idle();
    data = 16'hA5C3;
    ser_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    cyc = 0;
    got = 0;
    for (int i = 0; i < 400 && n < 7; i++) begin
      start = (cyc == 5);
      if (ser_valid_a[0]) begin
        got[n] = ser_bit_a[0];
        n++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    for (int i = 0; i < 20 && !ser_valid_a[0]; i++) tick();
    check("midscan_bits", 32'(got[6:0]), 32'h43);
    check("pre_reset_valid", 32'(ser_valid_a[0]), 1);
    reset_l = 1'b0;
    tick();
    check("scan_rst_sel", 32'({sel2_a[0], sel1_a[0]}), 0);
    check("scan_rst_ser_bit", 32'(ser_bit_a[0]), 0);
    check("scan_rst_valid", 32'(ser_valid_a[0]), 0);
    check("scan_rst_last", 32'(ser_last_a[0]), 0);
    check("scan_rst_busy", 32'(busy_a[0]), 0);
    check("scan_rst_done", 32'(done_a[0]), 0);
    check("scan_rst_parity", 32'(parity_a[0]), 0);
    reset_l = 1'b1;
    tick();
    check("post_rst_no_done", 32'(done_a), 0);
    run(tbl[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
